// File: rtl/sme_driver.sv
`default_nettype none
// ============================================================================
// sme_driver : host-side string/pattern transmitter for the matching engine
// Rev 1.0
// ============================================================================
module sme_driver #(
  parameter int STR_MAX     = 32,
  parameter int PAT_MAX     = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_en,
  input  logic       i_wr_sel,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_start,
  input  logic [5:0] i_s_len,
  input  logic [3:0] i_p_len,
  input  logic       i_new_string,
  output logic       o_busy,
  output logic [7:0] o_chardata,
  output logic       o_isstring,
  output logic       o_ispattern,
  input  logic       i_eng_valid,
  input  logic       i_eng_match,
  input  logic [4:0] i_eng_match_index,
  output logic       o_done,
  output logic       o_result_match,
  output logic [4:0] o_result_index,
  output logic       o_timeout
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_SEND_STR = 3'd1;
  localparam logic [2:0] c_SEND_PAT = 3'd2;
  localparam logic [2:0] c_WAIT     = 3'd3;
  localparam logic [2:0] c_REPORT   = 3'd4;

  localparam logic [5:0] c_S_MAX   = 6'(STR_MAX);
  localparam logic [3:0] c_P_MAX   = 4'(PAT_MAX);
  localparam logic [6:0] c_TO_LAST = 7'(TIMEOUT_CYC - 1);

  logic [7:0] r_str [STR_MAX];
  logic [7:0] r_pat [PAT_MAX];

  logic [2:0] r_state;
  logic       r_str_sent;
  logic [5:0] r_slen;
  logic [3:0] r_plen;
  logic [5:0] r_sidx;
  logic [3:0] r_pidx;
  logic [6:0] r_tcnt;

  logic [5:0] w_s_sat;
  logic [3:0] w_p_sat;
  logic       w_str_due;
  logic       w_accept;

  assign w_s_sat   = (i_s_len > c_S_MAX) ? c_S_MAX : i_s_len;
  assign w_p_sat   = (i_p_len > c_P_MAX) ? c_P_MAX : i_p_len;
  assign w_str_due = i_new_string || !r_str_sent;
  assign w_accept  = i_start && (i_p_len != 4'd0) && !(w_str_due && (i_s_len == 6'd0));

  // Buffers deliberately have no reset; contents survive a mid-job reset.
  always_ff @(posedge clk) begin
    if (i_wr_en && !o_busy) begin
      if (!i_wr_sel)
        r_str[i_wr_addr] <= i_wr_data;
      else if (i_wr_addr[4:3] == 2'b00)
        r_pat[i_wr_addr[2:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_IDLE;
      r_str_sent     <= 1'b0;
      r_slen         <= 6'd0;
      r_plen         <= 4'd0;
      r_sidx         <= 6'd0;
      r_pidx         <= 4'd0;
      r_tcnt         <= 7'd0;
      o_busy         <= 1'b0;
      o_chardata     <= 8'h00;
      o_isstring     <= 1'b0;
      o_ispattern    <= 1'b0;
      o_done         <= 1'b0;
      o_result_match <= 1'b0;
      o_result_index <= 5'd0;
      o_timeout      <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_slen <= w_s_sat;
            r_plen <= w_p_sat;
            o_busy <= 1'b1;
            // First char is registered on the accepting edge so it appears at T+1.
            if (w_str_due) begin
              r_state    <= c_SEND_STR;
              o_isstring <= 1'b1;
              o_chardata <= r_str[0];
              r_sidx     <= 6'd1;
            end else begin
              r_state     <= c_SEND_PAT;
              o_ispattern <= 1'b1;
              o_chardata  <= r_pat[0];
              r_pidx      <= 4'd1;
            end
          end
        end
        c_SEND_STR: begin
          if (r_sidx < r_slen) begin
            o_chardata <= r_str[r_sidx[4:0]];
            r_sidx     <= r_sidx + 6'd1;
          end else begin
            r_state     <= c_SEND_PAT;
            r_str_sent  <= 1'b1;
            o_isstring  <= 1'b0;
            o_ispattern <= 1'b1;
            o_chardata  <= r_pat[0];
            r_pidx      <= 4'd1;
          end
        end
        c_SEND_PAT: begin
          if (r_pidx < r_plen) begin
            o_chardata <= r_pat[r_pidx[2:0]];
            r_pidx     <= r_pidx + 4'd1;
          end else begin
            r_state     <= c_WAIT;
            o_ispattern <= 1'b0;
            o_chardata  <= 8'h00;
            r_tcnt      <= 7'd0;
          end
        end
        c_WAIT: begin
          if (i_eng_valid) begin
            r_state        <= c_REPORT;
            o_done         <= 1'b1;
            o_result_match <= i_eng_match;
            o_result_index <= i_eng_match_index;
            o_timeout      <= 1'b0;
          end else if (r_tcnt == c_TO_LAST) begin
            r_state        <= c_REPORT;
            o_done         <= 1'b1;
            o_result_match <= 1'b0;
            o_result_index <= 5'd0;
            o_timeout      <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 7'd1;
          end
        end
        c_REPORT: begin
          r_state <= c_IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= c_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sme_driver.sv
`default_nettype none
// tb_sme_driver : scoreboard bench for sme_driver (char stream and result timing).
module tb_sme_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_wr_en, i_wr_sel, i_start, i_new_string;
  logic [4:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic [5:0] i_s_len;
  logic [3:0] i_p_len;
  logic       i_eng_valid, i_eng_match;
  logic [4:0] i_eng_match_index;
  logic       o_busy, o_isstring, o_ispattern, o_done, o_result_match, o_timeout;
  logic [7:0] o_chardata;
  logic [4:0] o_result_index;

  sme_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_s_len(i_s_len), .i_p_len(i_p_len), .i_new_string(i_new_string),
    .o_busy(o_busy), .o_chardata(o_chardata), .o_isstring(o_isstring), .o_ispattern(o_ispattern),
    .i_eng_valid(i_eng_valid), .i_eng_match(i_eng_match), .i_eng_match_index(i_eng_match_index),
    .o_done(o_done), .o_result_match(o_result_match), .o_result_index(o_result_index),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = string char, 1 = pattern char, 2 = result
  typedef struct {
    int kind;
    int data;
    int m;
    int idx;
    int to;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   nchecks = 0;
  int   nerrors = 0;
  int   ndone   = 0;

  logic [7:0] m_str [32];
  logic [7:0] m_pat [8];
  bit         m_str_sent = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    nchecks++;
    if (act != req) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a char or a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_isstring && o_ispattern) begin
        nchecks++; nerrors++;
        $display("FAIL strobe_overlap: both strobes high at cycle %0d", cyc);
      end
      if (o_isstring || o_ispattern) begin
        nchecks++;
        if (q.size() == 0) begin
          nerrors++;
          $display("FAIL unexpected_char: got %h at cycle %0d, expected none", o_chardata, cyc);
        end else begin
          e_mon = q.pop_front();
          if (e_mon.kind != (o_ispattern ? 1 : 0) || e_mon.data != int'(o_chardata) || e_mon.cyc != cyc) begin
            nerrors++;
            $display("FAIL char: got kind=%0d ch=%h cyc=%0d expected kind=%0d ch=%h cyc=%0d",
                     o_ispattern ? 1 : 0, o_chardata, cyc, e_mon.kind, e_mon.data, e_mon.cyc);
          end
        end
      end else if (o_chardata != 8'h00) begin
        nchecks++; nerrors++;
        $display("FAIL idle_chardata: got %h expected 00 at cycle %0d", o_chardata, cyc);
      end
      if (o_done) begin
        ndone++;
        nchecks++;
        if (q.size() == 0) begin
          nerrors++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e_mon = q.pop_front();
          if (e_mon.kind != 2 || e_mon.m != int'(o_result_match) || e_mon.idx != int'(o_result_index) ||
              e_mon.to != int'(o_timeout) || e_mon.cyc != cyc) begin
            nerrors++;
            $display("FAIL result: got m=%0d idx=%0d to=%0d cyc=%0d expected kind=%0d m=%0d idx=%0d to=%0d cyc=%0d",
                     o_result_match, o_result_index, o_timeout, cyc,
                     e_mon.kind, e_mon.m, e_mon.idx, e_mon.to, e_mon.cyc);
          end
        end
      end
    end
  end

  task automatic wr(input bit sel, input int addr, input logic [7:0] d);
    i_wr_en = 1'b1; i_wr_sel = sel; i_wr_addr = addr[4:0]; i_wr_data = d;
    @(negedge clk);
    i_wr_en = 1'b0;
    if (!sel) m_str[addr] = d;
    else if (addr < 8) m_pat[addr] = d;
  endtask

  task automatic wstr(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) wr(sel, i, s[i]);
  endtask

  // dly < 0: engine stays silent (timeout). abort_at >= 0: reset that many cycles after start.
  task automatic run_job(input bit ns, input logic [5:0] sl, input logic [3:0] pl, input int dly,
                         input bit em, input logic [4:0] ei, input bit inj, input int abort_at);
    int se, pe, ss, t, e;
    bit sd, seen;
    exp_t x;
    se = (sl > 6'd32) ? 32 : int'(sl);
    pe = (pl > 4'd8) ? 8 : int'(pl);
    sd = ns || !m_str_sent;
    ss = sd ? se : 0;
    t  = cyc;
    for (int k = 0; k < ss; k++) begin
      x = '{0, int'(m_str[k]), 0, 0, 0, t + 1 + k};
      q.push_back(x);
    end
    for (int k = 0; k < pe; k++) begin
      x = '{1, int'(m_pat[k]), 0, 0, 0, t + 1 + ss + k};
      q.push_back(x);
    end
    e = t + ss + pe + 1;
    if (dly >= 0) x = '{2, 0, int'(em), int'(ei), 0, e + dly + 1};
    else          x = '{2, 0, 0, 0, 1, e + 64};
    q.push_back(x);

    i_start = 1'b1; i_new_string = ns; i_s_len = sl; i_p_len = pl;
    @(negedge clk);
    i_start = 1'b0;
    if (sd) m_str_sent = 1'b1;

    if (inj) begin
      @(negedge clk);
      i_start = 1'b1; i_new_string = 1'b1;
      i_wr_en = 1'b1; i_wr_sel = 1'b1; i_wr_addr = 5'd0; i_wr_data = 8'h41;
      @(negedge clk);
      i_start = 1'b0; i_wr_en = 1'b0;
    end

    if (abort_at >= 0) begin
      while (cyc < t + abort_at) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_isstring", int'(o_isstring), 0);
      chk("abort_ispattern", int'(o_ispattern), 0);
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_chardata", int'(o_chardata), 0);
      q.delete();
      m_str_sent = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end

    if (dly >= 0) begin
      while (cyc < e + dly) @(negedge clk);
      i_eng_valid = 1'b1; i_eng_match = em; i_eng_match_index = ei;
      @(negedge clk);
      i_eng_valid = 1'b0; i_eng_match = 1'b0; i_eng_match_index = 5'd0;
    end

    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      nchecks++; nerrors++;
      $display("FAIL done_wait: got no done within 200 cycles, expected one");
    end
    @(negedge clk);
    chk("busy_after_report", int'(o_busy), 0);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    i_wr_en = 1'b0; i_wr_sel = 1'b0; i_wr_addr = 5'd0; i_wr_data = 8'h00;
    i_start = 1'b0; i_new_string = 1'b0; i_s_len = 6'd0; i_p_len = 4'd0;
    i_eng_valid = 1'b0; i_eng_match = 1'b0; i_eng_match_index = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_chardata", int'(o_chardata), 0);
    chk("rst_isstring", int'(o_isstring), 0);
    chk("rst_ispattern", int'(o_ispattern), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_result", int'({o_result_match, o_result_index, o_timeout}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First job after reset: string forced even with new_string=0.
    wstr(1'b0, "abcd");
    wstr(1'b1, "xy");
    run_job(1'b0, 6'd4, 4'd2, 2, 1'b1, 5'd1, 1'b0, -1);

    // Basic match.
    wstr(1'b0, "hello world");
    wstr(1'b1, "wor");
    run_job(1'b1, 6'd11, 4'd3, 3, 1'b1, 5'd6, 1'b0, -1);

    // Pattern-only reuse.
    wstr(1'b1, "xyz");
    run_job(1'b0, 6'd11, 4'd3, 0, 1'b0, 5'd0, 1'b0, -1);

    // Out-of-range pattern write must not alias onto pattern[0].
    wr(1'b1, 8, 8'h51);
    // Busy rules: start and pattern write during SEND_STR are dropped.
    run_job(1'b1, 6'd11, 4'd3, 5, 1'b1, 5'd2, 1'b1, -1);

    i_start = 1'b1; i_new_string = 1'b0; i_s_len = 6'd4; i_p_len = 4'd0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("plen0_busy", int'(o_busy), 0);
    i_start = 1'b1; i_new_string = 1'b1; i_s_len = 6'd0; i_p_len = 4'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("slen0_busy", int'(o_busy), 0);

    // Timeout: pattern[0] still 'x' confirms ignored writes.
    run_job(1'b0, 6'd11, 4'd3, -1, 1'b0, 5'd0, 1'b0, -1);
    chk("timeout_held", int'(o_timeout), 1);

    // Saturation then reset mid-SEND_PAT.
    for (int i = 0; i < 32; i++) wr(1'b0, i, 8'h41 + 8'(i));
    for (int i = 0; i < 8; i++)  wr(1'b1, i, 8'h61 + 8'(i));
    nd = ndone;
    run_job(1'b1, 6'd40, 4'd12, -1, 1'b0, 5'd0, 1'b0, 36);
    repeat (80) @(negedge clk);
    chk("abort_no_done", ndone, nd);
    chk("abort_idle", int'(o_busy), 0);

    // After reset the string is resent although new_string=0.
    run_job(1'b0, 6'd5, 4'd2, 1, 1'b1, 5'd3, 1'b0, -1);

    repeat (4) @(negedge clk);
    chk("total_done", ndone, 6);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sme_driver.md
Name: sme_driver

Overview:
- Host-side transmitter for the string-matching engine protocol; the matcher consumes this block's output stream.
- Buffers one string of up to 32 chars and one pattern of up to 8 chars written by the host.
- On start, streams the string (optional) and then the pattern as `chardata` with `isstring`/`ispattern` strobes.
- Waits for the engine's `valid`, then returns `match`/`match_index` to the host with a one-cycle `done` pulse.

Parameters:
- STR_MAX, 32, string buffer depth (chars).
- PAT_MAX, 8, pattern buffer depth (chars).
- TIMEOUT_CYC, 64, max WAIT cycles before the job is aborted.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host buffer write strobe.
- wr_sel  in  1  0 = string buffer, 1 = pattern buffer.
- wr_addr  in  5  char index (pattern uses bits [2:0]).
- wr_data  in  8  char value.
- start  in  1  job request; sampled only in IDLE.
- s_len  in  6  string length, 1..32; values >32 saturate to 32.
- p_len  in  4  pattern length, 1..8; values >8 saturate to 8.
- new_string  in  1  1 = send string then pattern; 0 = send pattern only.
- busy  out  1  high in every state except IDLE.
- chardata  out  8  char to engine.
- isstring  out  1  string char strobe.
- ispattern  out  1  pattern char strobe.
- eng_valid  in  1  engine result valid.
- eng_match  in  1  engine match flag.
- eng_match_index  in  5  engine match index.
- done  out  1  one-cycle result pulse.
- result_match  out  1  captured match; held until next done.
- result_index  out  5  captured index; held until next done.
- timeout  out  1  qualifies done: job aborted without eng_valid.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; str_sent=0; all outputs 0 (chardata=8'h00).
  - Buffer contents are not reset.
- Outputs: all registered; no combinational path from inputs to outputs.
- Writes:
  - Accepted only when busy=0; ignored while busy.
  - wr_sel=1 with wr_addr>=8 is ignored.
- State machine (IDLE, SEND_STR, SEND_PAT, WAIT, REPORT):
  - IDLE: when start=1 and p_len!=0, latch s_len/p_len (saturated) and go to SEND_STR if (new_string=1 or str_sent=0), else SEND_PAT.
    - start with p_len==0 is ignored.
    - s_len==0 with a string send due is also ignored.
  - SEND_STR:
    - One char per cycle: isstring=1, chardata=string[i], i = 0..s_len-1.
    - First char appears the cycle after start is sampled.
    - After the last char, go to SEND_PAT with no gap cycle.
    - Set str_sent=1.
  - SEND_PAT:
    - ispattern=1, chardata=pattern[j], j = 0..p_len-1, contiguous.
    - isstring and ispattern are never high together.
    - Next state WAIT.
  - WAIT:
    - isstring=ispattern=0, chardata=0.
    - Cycle counter starts at 0.
    - eng_valid=1 in any WAIT cycle: capture eng_match/eng_match_index, go to REPORT with timeout=0.
    - Counter reaching TIMEOUT_CYC-1 without eng_valid: result_match=0, result_index=0, go to REPORT with timeout=1.
  - REPORT:
    - done=1 for exactly one cycle; timeout valid in the same cycle.
    - Return to IDLE; busy drops in the cycle after REPORT.
- eng_valid outside WAIT is ignored.
- start during busy is ignored; it is not queued.
- Latency, new_string=1: first isstring at T+1; last ispattern at T+s_len+p_len; done = (engine response cycles) + 1 after WAIT entry.
- Reset mid-job:
  - Strobes drop immediately; no done is issued.
  - str_sent=0, so the next job resends the string.
- Counters: i is 6 bits, j is 4 bits, timeout counter is 7 bits. Compare against latched lengths; no wrap beyond them.

Test Plan:
- Basic match: write string "hello world" (11 chars) and pattern "wor"; start with new_string=1, s_len=11, p_len=3. Required: isstring high for cycles 1..11, ispattern high for cycles 12..14, chars in order; engine model returns match=1, index=6; done pulse with result_match=1, result_index=6, timeout=0.
- Pattern-only reuse: after the first job, write pattern "xyz"; start with new_string=0, p_len=3. Required: no isstring cycles, ispattern for 3 cycles starting T+1; engine returns match=0; result_match=0.
- First-job forced string: immediately after reset, start with new_string=0, s_len=4, p_len=2. Required: 4 isstring cycles are still sent before ispattern.
- Timeout: engine model never asserts valid. Required: done at WAIT entry + 64 cycles with timeout=1, result_match=0, result_index=0.
- Busy rules: pulse start and wr_en (pattern addr 0 = 8'h41) during SEND_STR. Required: second start ignored, buffer unchanged, one done per job; start with p_len=0 in IDLE produces no activity.
- Saturation / reset: start with s_len=40. Required: exactly 32 isstring cycles. Assert reset low in the middle of SEND_PAT. Required: strobes go to 0 asynchronously and no done is issued.
